axi_sram_subordinate: RTL and testbench
=======================================

// Module: axi_sram_subordinate
// PURPOSE
//  AXI subordinate (responder) backed by an internal word-addressed RAM; other end of an axi_if manager.
//  Serves one transaction at a time: AW+W+B or AR+R, with FIXED, INCR and WRAP bursts and byte strobes.
//  Used as boot/scratch memory and as the canonical responder in AXI manager testbenches.
// PARAMETERS
//  DEPTH_WORDS  1024               RAM depth in DWIDTH-bit words; power of two
//  AWIDTH       axi_pkg::AWIDTH    address width; must match the connected axi_if
//  DWIDTH       axi_pkg::DWIDTH    data width; multiple of 8
//  IDWIDTH      axi_pkg::IDWIDTH   ID width
//  LENWIDTH     axi_pkg::LENWIDTH  AxLEN width
// PORTS
//  i_aclk    in   1   clock; all state changes on rising edge
//  i_arst_n  in   1   asynchronous active-low reset
//  axi       if   -   axi_if.subordinate; drives awready, wready, bvalid/bid/bresp, arready, rvalid/rid/rdata/rresp/rlast
// BEHAVIOUR
//  Reset (async assert): state=IDLE; awready, wready, bvalid, arready, rvalid, rlast = 0; bid, rid, rdata = 0;
//   bresp, rresp = OKAY; RAM contents not reset and preserved. Reset mid-burst abandons the transaction, no response issued.
//  FSM: IDLE -> WDATA -> WRESP -> IDLE;  IDLE -> RDATA -> IDLE.
//  IDLE: awready = arready = 1 only for the granted channel. Both awvalid and arvalid set: round-robin, starting
//   with read after reset, then alternating after each grant. AW/AR handshake captures id, addr, len, size, burst.
//  Beat address: word index = addr >> $clog2(DWIDTH/8); low byte bits ignored (aligned transfers only).
//   INCR: +1 word per beat. FIXED: constant. WRAP: wraps at (len+1)-word boundary, lower index bits only.
//  Error checks at the A handshake (resp applies to the whole burst):
//   size != $clog2(DWIDTH/8), or WRAP with len not in {1,3,7,15} -> SLVERR.
//   Any beat word index >= DEPTH_WORDS -> DECERR for that beat, no RAM access, read data 0.
//   SLVERR suppresses all RAM writes; read data returned as 0.
//  WDATA: wready = 1; each W handshake writes bytes whose wstrb bit is 1; beat counter increments.
//   wid ignored. Ends on beat len+1. wlast != (beat == len) on any beat -> bresp forced to SLVERR.
//   W handshake while in IDLE is not accepted (wready = 0 outside WDATA).
//  WRESP: bvalid = 1, bid = captured awid, bresp = worst of OKAY < SLVERR < DECERR seen during the burst;
//   held stable until bready; handshake -> IDLE. awready deasserted while in WRESP.
//  RDATA: rvalid asserts the cycle after the AR handshake; rdata, rid = arid, rresp, rlast (beat == len) are
//   registered and held stable until rready. On R handshake the next beat is presented the following cycle
//   with no bubble (rvalid stays 1); on the last-beat handshake rvalid -> 0 and state -> IDLE.
//  Throughput: writes 1 beat/cycle after AW; reads 1 beat/cycle after a 1-cycle initial latency.
//  len = 0 is a single beat; len = max (2^LENWIDTH-1) uses a LENWIDTH+1 bit counter, no overflow.
//  INCR past DEPTH_WORDS-1 does not wrap the RAM; remaining beats return DECERR.
//  Read of a word written in the immediately preceding burst returns the new data.
// TESTING
//  Single write: AW addr 0x10, len 0, wdata 0xDEADBEEF, wstrb all 1s -> bresp OKAY; AR 0x10 -> rdata 0xDEADBEEF, rlast 1.
//  INCR read: len 3 from word 4 after writing 4..7 = 1,2,3,4 -> 4 beats 1,2,3,4, rlast only on beat 4, rready held
//   low 2 cycles on beat 2 -> data and rvalid stable.
//  WRAP read: len 3 starting word 6 -> beat order words 6,7,4,5. WRAP with len 2 -> SLVERR on all beats, data 0.
//  Strobes: write 0xAABBCCDD then 0x11223344 with wstrb 0b0101 (DWIDTH=32) -> read 0xAA22CC44.
//  Errors: addr = DEPTH_WORDS*bytes -> bresp/rresp DECERR; early wlast on beat 1 of a len 3 burst -> bresp SLVERR.
//  Arbitration and reset: awvalid and arvalid together -> read first, then write. Assert i_arst_n low mid-read burst
//   -> rvalid 0 immediately; after release a new AR completes normally and prior RAM data is intact.

Source files
------------

// File: rtl/axi_sram_subordinate_if.sv
// AXI bus constants and the manager/subordinate interface shared by the SRAM responder
// and the managers that talk to it.
package axi_pkg;
  localparam int AWIDTH   = 32;
  localparam int DWIDTH   = 32;
  localparam int IDWIDTH  = 4;
  localparam int LENWIDTH = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
endpackage

interface axi_if #(
  parameter int AWIDTH   = axi_pkg::AWIDTH,
  parameter int DWIDTH   = axi_pkg::DWIDTH,
  parameter int IDWIDTH  = axi_pkg::IDWIDTH,
  parameter int LENWIDTH = axi_pkg::LENWIDTH
);
  logic                  awvalid, awready;
  logic [IDWIDTH-1:0]    awid;
  logic [AWIDTH-1:0]     awaddr;
  logic [LENWIDTH-1:0]   awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;

  logic                  wvalid, wready;
  logic [IDWIDTH-1:0]    wid;
  logic [DWIDTH-1:0]     wdata;
  logic [DWIDTH/8-1:0]   wstrb;
  logic                  wlast;

  logic                  bvalid, bready;
  logic [IDWIDTH-1:0]    bid;
  logic [1:0]            bresp;

  logic                  arvalid, arready;
  logic [IDWIDTH-1:0]    arid;
  logic [AWIDTH-1:0]     araddr;
  logic [LENWIDTH-1:0]   arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;

  logic                  rvalid, rready;
  logic [IDWIDTH-1:0]    rid;
  logic [DWIDTH-1:0]     rdata;
  logic [1:0]            rresp;
  logic                  rlast;

  modport manager (
    output awvalid, awid, awaddr, awlen, awsize, awburst,
    output wvalid, wid, wdata, wstrb, wlast, bready,
    output arvalid, arid, araddr, arlen, arsize, arburst, rready,
    input  awready, wready, bvalid, bid, bresp,
    input  arready, rvalid, rid, rdata, rresp, rlast
  );

  modport subordinate (
    input  awvalid, awid, awaddr, awlen, awsize, awburst,
    input  wvalid, wid, wdata, wstrb, wlast, bready,
    input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
    output awready, wready, bvalid, bid, bresp,
    output arready, rvalid, rid, rdata, rresp, rlast
  );
endinterface

// File: rtl/axi_sram_subordinate.sv
// AXI subordinate backed by a byte-lane RAM; serves one AW+W+B or AR+R burst at a time
// with FIXED/INCR/WRAP addressing, byte strobes and OKAY/SLVERR/DECERR responses.

module axi_sram_lane #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wd,
  output logic [7:0]    rd
);
  // Contents are deliberately not reset so data survives a bus reset.
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wd;
  end

  assign rd = mem[addr];
endmodule

module axi_sram_subordinate #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AWIDTH      = axi_pkg::AWIDTH,
  parameter int DWIDTH      = axi_pkg::DWIDTH,
  parameter int IDWIDTH     = axi_pkg::IDWIDTH,
  parameter int LENWIDTH    = axi_pkg::LENWIDTH
) (
  input  logic        i_aclk,
  input  logic        i_arst_n,
  axi_if.subordinate  axi
);
  import axi_pkg::*;

  localparam int NUM_LANES = DWIDTH / 8;
  localparam int SH        = $clog2(NUM_LANES);
  localparam int RAW       = $clog2(DEPTH_WORDS);
  localparam int IW        = AWIDTH - SH + 1;   // spare MSB: INCR never wraps the index
  localparam int BW        = LENWIDTH + 1;
  localparam logic [2:0] SIZE_OK = 3'(SH);

  typedef enum logic [1:0] {S_IDLE, S_WDATA, S_WRESP, S_RDATA} state_t;

  typedef struct packed {
    logic [IDWIDTH-1:0]  id;
    logic [LENWIDTH-1:0] len;
    logic [1:0]          burst;
    logic                slverr;
  } areq_t;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] cur, input logic [1:0] burst,
                                             input logic [LENWIDTH-1:0] len);
    logic [IW-1:0] mask;
    mask = IW'(len);
    case (burst)
      BURST_INCR: return cur + IW'(1);
      BURST_WRAP: return (cur & ~mask) | ((cur + IW'(1)) & mask);
      default:    return cur;
    endcase
  endfunction

  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  state_t              state, state_nxt;
  logic                wr_prio;
  areq_t               req, a_req;
  logic [IW-1:0]       idx, a_idx, nxt_idx, ram_idx;
  logic [BW-1:0]       beat, last_beat;
  logic [1:0]          resp_acc, ram_resp, w_beat_resp;
  logic                grant_w, grant_r, w_hs, r_hs, wlast_bad, slv_sel;

  logic                bvalid_q, rvalid_q, rlast_q;
  logic [IDWIDTH-1:0]  bid_q, rid_q;
  logic [1:0]          bresp_q, rresp_q;
  logic [DWIDTH-1:0]   rdata_q, rd_word;

  logic [NUM_LANES-1:0]        lane_we;
  logic [NUM_LANES-1:0][7:0]   wd_l, rd_l;

  logic unused_bits;
  assign unused_bits = ^{axi.wid, axi.awaddr[SH-1:0], axi.araddr[SH-1:0]};

  // Round robin: after a read grant, writes win the next tie, and vice versa.
  always_comb begin
    grant_w = 1'b0;
    grant_r = 1'b0;
    if (state == S_IDLE) begin
      if (axi.awvalid && axi.arvalid) begin
        grant_w = wr_prio;
        grant_r = !wr_prio;
      end else begin
        grant_w = axi.awvalid;
        grant_r = axi.arvalid;
      end
    end
  end

  always_comb begin
    a_req.id    = grant_w ? axi.awid    : axi.arid;
    a_req.len   = grant_w ? axi.awlen   : axi.arlen;
    a_req.burst = grant_w ? axi.awburst : axi.arburst;
    a_idx       = grant_w ? {1'b0, axi.awaddr[AWIDTH-1:SH]} : {1'b0, axi.araddr[AWIDTH-1:SH]};
    a_req.slverr = ((grant_w ? axi.awsize : axi.arsize) != SIZE_OK) ||
                   (a_req.burst == 2'b11) ||
                   ((a_req.burst == BURST_WRAP) &&
                    !((a_req.len == LENWIDTH'(1)) || (a_req.len == LENWIDTH'(3)) ||
                      (a_req.len == LENWIDTH'(7)) || (a_req.len == LENWIDTH'(15))));
  end

  assign last_beat = {1'b0, req.len};
  assign nxt_idx   = next_idx(idx, req.burst, req.len);
  assign w_hs      = (state == S_WDATA) && axi.wvalid;
  assign r_hs      = (state == S_RDATA) && rvalid_q && axi.rready;

  // RAM port: A-phase address in IDLE (first read beat), upcoming beat while reading.
  always_comb begin
    case (state)
      S_IDLE:  ram_idx = a_idx;
      S_RDATA: ram_idx = nxt_idx;
      default: ram_idx = idx;
    endcase
  end

  assign slv_sel     = (state == S_IDLE) ? a_req.slverr : req.slverr;
  assign ram_resp    = (ram_idx[IW-1:RAW] != '0) ? RESP_DECERR :
                       slv_sel                   ? RESP_SLVERR : RESP_OKAY;
  assign wlast_bad   = axi.wlast != (beat == last_beat);
  assign w_beat_resp = resp_max(resp_acc, resp_max(ram_resp, wlast_bad ? RESP_SLVERR : RESP_OKAY));

  assign wd_l    = axi.wdata;
  assign lane_we = (w_hs && (ram_resp == RESP_OKAY)) ? axi.wstrb : '0;
  assign rd_word = (ram_resp == RESP_OKAY) ? rd_l : '0;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    axi_sram_lane #(.DEPTH(DEPTH_WORDS), .AW(RAW)) u_lane (
      .clk  (i_aclk),
      .we   (lane_we[i]),
      .addr (ram_idx[RAW-1:0]),
      .wd   (wd_l[i]),
      .rd   (rd_l[i])
    );
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (grant_w)      state_nxt = S_WDATA;
        else if (grant_r) state_nxt = S_RDATA;
      end
      S_WDATA: if (w_hs && (beat == last_beat)) state_nxt = S_WRESP;
      S_WRESP: if (axi.bready)                  state_nxt = S_IDLE;
      S_RDATA: if (r_hs && rlast_q)             state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_aclk or negedge i_arst_n) begin
    if (!i_arst_n) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_ff @(posedge i_aclk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      wr_prio  <= 1'b0;
      req      <= '0;
      idx      <= '0;
      beat     <= '0;
      resp_acc <= RESP_OKAY;
      bvalid_q <= 1'b0;
      bid_q    <= '0;
      bresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      rid_q    <= '0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      rlast_q  <= 1'b0;
    end else begin
      if (grant_w || grant_r) begin
        wr_prio  <= grant_r;
        req      <= a_req;
        idx      <= a_idx;
        beat     <= '0;
        resp_acc <= RESP_OKAY;
      end
      if (grant_r) begin
        rvalid_q <= 1'b1;
        rid_q    <= a_req.id;
        rdata_q  <= rd_word;
        rresp_q  <= ram_resp;
        rlast_q  <= (a_req.len == '0);
      end
      if (w_hs) begin
        idx      <= nxt_idx;
        beat     <= beat + BW'(1);
        resp_acc <= w_beat_resp;
        if (beat == last_beat) begin
          bvalid_q <= 1'b1;
          bid_q    <= req.id;
          bresp_q  <= w_beat_resp;
        end
      end
      if ((state == S_WRESP) && axi.bready) bvalid_q <= 1'b0;
      if (r_hs) begin
        if (rlast_q) begin
          rvalid_q <= 1'b0;
          rlast_q  <= 1'b0;
        end else begin
          idx     <= nxt_idx;
          beat    <= beat + BW'(1);
          rdata_q <= rd_word;
          rresp_q <= ram_resp;
          rlast_q <= ((beat + BW'(1)) == last_beat);
        end
      end
    end
  end

  assign axi.awready = grant_w;
  assign axi.arready = grant_r;
  assign axi.wready  = (state == S_WDATA);
  assign axi.bvalid  = bvalid_q;
  assign axi.bid     = bid_q;
  assign axi.bresp   = bresp_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rid     = rid_q;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;
  assign axi.rlast   = rlast_q;
endmodule

// File: tb/tb_axi_sram_subordinate.sv
// Directed bench for axi_sram_subordinate: writes, reads, bursts, strobes, errors,
// arbitration and mid-burst reset, with hand-computed expectations.
module tb_axi_sram_subordinate;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_if bus();

  axi_sram_subordinate #(.DEPTH_WORDS(1024)) dut (
    .i_aclk   (clk),
    .i_arst_n (rst_n),
    .axi      (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] wbuf  [256];
  logic [3:0]  sbuf  [256];
  logic [31:0] rbuf  [256];
  logic [1:0]  rrbuf [256];
  logic        rlbuf [256];
  logic [3:0]  ridbuf[256];
  logic [31:0] stall_d[2];
  logic        stall_v[2];
  int          first_wait, gaps, stall_n;
  logic [1:0]  b_resp;
  logic [3:0]  b_id;

  task automatic send_aw(input logic [31:0] addr, input int len, input logic [1:0] burst,
                         input logic [2:0] size, input logic [3:0] id);
    logic hs;
    hs = 1'b0;
    bus.awaddr = addr; bus.awlen = 8'(len); bus.awburst = burst; bus.awsize = size;
    bus.awid = id; bus.awvalid = 1'b1;
    for (int n = 0; n < 100 && !hs; n++) begin
      @(negedge clk); hs = bus.awready;
      @(posedge clk); #1;
    end
    bus.awvalid = 1'b0;
    if (!hs) begin checks++; errors++; $display("FAIL aw_timeout awready got 0 want 1"); end
  endtask

  task automatic send_ar(input logic [31:0] addr, input int len, input logic [1:0] burst,
                         input logic [2:0] size, input logic [3:0] id);
    logic hs;
    hs = 1'b0;
    bus.araddr = addr; bus.arlen = 8'(len); bus.arburst = burst; bus.arsize = size;
    bus.arid = id; bus.arvalid = 1'b1;
    for (int n = 0; n < 100 && !hs; n++) begin
      @(negedge clk); hs = bus.arready;
      @(posedge clk); #1;
    end
    bus.arvalid = 1'b0;
    if (!hs) begin checks++; errors++; $display("FAIL ar_timeout arready got 0 want 1"); end
  endtask

  task automatic send_w(input int len, input int early);
    logic hs;
    for (int b = 0; b <= len; b++) begin
      bus.wdata = wbuf[b]; bus.wstrb = sbuf[b]; bus.wid = 4'hA; bus.wvalid = 1'b1;
      bus.wlast = (early < 0) ? (b == len) : (b == early);
      hs = 1'b0;
      for (int n = 0; n < 100 && !hs; n++) begin
        @(negedge clk); hs = bus.wready;
        @(posedge clk); #1;
      end
      if (!hs) begin checks++; errors++; $display("FAIL w_timeout beat %0d wready got 0 want 1", b); end
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
  endtask

  task automatic recv_b();
    logic hs;
    hs = 1'b0;
    bus.bready = 1'b1;
    for (int n = 0; n < 100 && !hs; n++) begin
      @(negedge clk);
      hs = bus.bvalid; b_resp = bus.bresp; b_id = bus.bid;
      @(posedge clk); #1;
    end
    bus.bready = 1'b0;
    if (!hs) begin checks++; errors++; $display("FAIL b_timeout bvalid got 0 want 1"); end
  endtask

  task automatic recv_r(input int len, input int stall_beat);
    int beat;
    beat = 0; first_wait = 0; gaps = 0; stall_n = 0;
    for (int n = 0; n < 600 && beat <= len; n++) begin
      bus.rready = !((beat == stall_beat) && (stall_n < 2));
      @(negedge clk);
      if (!bus.rready) begin
        stall_d[stall_n] = bus.rdata; stall_v[stall_n] = bus.rvalid; stall_n++;
      end else if (bus.rvalid) begin
        rbuf[beat] = bus.rdata; rrbuf[beat] = bus.rresp; rlbuf[beat] = bus.rlast;
        ridbuf[beat] = bus.rid; beat++;
      end else if (beat == 0) first_wait++;
      else gaps++;
      @(posedge clk); #1;
    end
    bus.rready = 1'b0;
    if (beat <= len) begin checks++; errors++; $display("FAIL r_timeout beats got %0d want %0d", beat, len + 1); end
  endtask

  task automatic wr(input logic [31:0] addr, input int len, input logic [1:0] burst, input logic [3:0] id);
    send_aw(addr, len, burst, 3'd2, id);
    send_w(len, -1);
    recv_b();
  endtask

  task automatic rd(input logic [31:0] addr, input int len, input logic [1:0] burst, input logic [3:0] id);
    send_ar(addr, len, burst, 3'd2, id);
    recv_r(len, -1);
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.rlast} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 000000",
        {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.rlast});
    end
    checks++;
    if ({bus.bid, bus.rid, bus.rdata, bus.bresp, bus.rresp} !== 44'h0) begin
      errors++; $display("FAIL reset_data got bid %0h rid %0h rdata %0h bresp %0h rresp %0h want all 0",
        bus.bid, bus.rid, bus.rdata, bus.bresp, bus.rresp);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    bus.wvalid = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.wready !== 1'b0) begin errors++; $display("FAIL idle_wready got %b want 0", bus.wready); end
    @(posedge clk); #1;
    bus.wvalid = 1'b0;
  endtask

  task automatic test_single();
    wbuf[0] = 32'hDEADBEEF;
    send_aw(32'h10, 0, 2'b01, 3'd2, 4'h3);
    send_w(0, -1);
    bus.awvalid = 1'b1; bus.awaddr = 32'h40; bus.awlen = 8'd0;
    @(negedge clk);
    checks++;
    if (bus.awready !== 1'b0 || bus.bvalid !== 1'b1) begin
      errors++; $display("FAIL wresp_hold got awready %b bvalid %b want 0 1", bus.awready, bus.bvalid);
    end
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    recv_b();
    checks++;
    if (b_resp !== 2'b00 || b_id !== 4'h3) begin
      errors++; $display("FAIL single_b got resp %0h id %0h want 0 3", b_resp, b_id);
    end
    rd(32'h10, 0, 2'b01, 4'h5);
    checks++;
    if (rbuf[0] !== 32'hDEADBEEF || rrbuf[0] !== 2'b00 || rlbuf[0] !== 1'b1 || ridbuf[0] !== 4'h5) begin
      errors++; $display("FAIL single_r got data %h resp %0h last %b id %0h want deadbeef 0 1 5",
        rbuf[0], rrbuf[0], rlbuf[0], ridbuf[0]);
    end
    checks++;
    if (first_wait !== 0) begin errors++; $display("FAIL single_latency got %0d want 0", first_wait); end
  endtask

  task automatic test_incr_read();
    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    wr(32'h10, 3, 2'b01, 4'h1);
    checks++;
    if (b_resp !== 2'b00) begin errors++; $display("FAIL incr_wr_b got %0h want 0", b_resp); end
    send_ar(32'h10, 3, 2'b01, 3'd2, 4'h2);
    recv_r(3, 1);
    checks++;
    if (rbuf[0] !== 32'd1 || rbuf[1] !== 32'd2 || rbuf[2] !== 32'd3 || rbuf[3] !== 32'd4) begin
      errors++; $display("FAIL incr_data got %0h %0h %0h %0h want 1 2 3 4", rbuf[0], rbuf[1], rbuf[2], rbuf[3]);
    end
    checks++;
    if ({rlbuf[0], rlbuf[1], rlbuf[2], rlbuf[3]} !== 4'b0001) begin
      errors++; $display("FAIL incr_rlast got %b want 0001", {rlbuf[0], rlbuf[1], rlbuf[2], rlbuf[3]});
    end
    checks++;
    if (stall_n !== 2 || stall_d[0] !== 32'd2 || stall_d[1] !== 32'd2 || stall_v[0] !== 1'b1 || stall_v[1] !== 1'b1) begin
      errors++; $display("FAIL incr_stall got n %0d data %0h %0h valid %b %b want 2 2 2 1 1",
        stall_n, stall_d[0], stall_d[1], stall_v[0], stall_v[1]);
    end
    checks++;
    if (gaps !== 0) begin errors++; $display("FAIL incr_bubbles got %0d want 0", gaps); end
  endtask

  task automatic test_wrap();
    rd(32'h18, 3, 2'b10, 4'h0);
    checks++;
    if (rbuf[0] !== 32'd3 || rbuf[1] !== 32'd4 || rbuf[2] !== 32'd1 || rbuf[3] !== 32'd2 || rlbuf[3] !== 1'b1) begin
      errors++; $display("FAIL wrap_order got %0h %0h %0h %0h last %b want 3 4 1 2 1",
        rbuf[0], rbuf[1], rbuf[2], rbuf[3], rlbuf[3]);
    end
    rd(32'h18, 2, 2'b10, 4'h0);
    checks++;
    if ({rrbuf[0], rrbuf[1], rrbuf[2]} !== 6'b101010 || rbuf[0] !== 0 || rbuf[1] !== 0 || rbuf[2] !== 0) begin
      errors++; $display("FAIL wrap_len2_r got resp %0h %0h %0h data %0h %0h %0h want 2 2 2 0 0 0",
        rrbuf[0], rrbuf[1], rrbuf[2], rbuf[0], rbuf[1], rbuf[2]);
    end
    for (int i = 0; i < 3; i++) wbuf[i] = 32'hBAD0_0000;
    wr(32'h18, 2, 2'b10, 4'h0);
    checks++;
    if (b_resp !== 2'b10) begin errors++; $display("FAIL wrap_len2_b got %0h want 2", b_resp); end
    rd(32'h18, 0, 2'b01, 4'h0);
    checks++;
    if (rbuf[0] !== 32'd3) begin errors++; $display("FAIL slverr_nowrite got %0h want 3", rbuf[0]); end
  endtask

  task automatic test_strobe();
    wbuf[0] = 32'hAABBCCDD;
    wr(32'h50, 0, 2'b01, 4'h0);
    wbuf[0] = 32'h11223344; sbuf[0] = 4'b0101;
    wr(32'h50, 0, 2'b01, 4'h0);
    sbuf[0] = 4'hF;
    rd(32'h50, 0, 2'b01, 4'h0);
    checks++;
    if (rbuf[0] !== 32'hAA22CC44) begin errors++; $display("FAIL strobe got %h want aa22cc44", rbuf[0]); end
  endtask

  task automatic test_fixed();
    wbuf[0] = 32'd5; wbuf[1] = 32'd6; wbuf[2] = 32'd7;
    wr(32'hA0, 2, 2'b00, 4'h0);
    rd(32'hA0, 1, 2'b00, 4'h0);
    checks++;
    if (rbuf[0] !== 32'd7 || rbuf[1] !== 32'd7 || rlbuf[0] !== 1'b0 || rlbuf[1] !== 1'b1) begin
      errors++; $display("FAIL fixed got %0h %0h last %b%b want 7 7 01", rbuf[0], rbuf[1], rlbuf[0], rlbuf[1]);
    end
  endtask

  task automatic test_errors();
    wbuf[0] = 32'h1234;
    wr(32'h1000, 0, 2'b01, 4'h0);
    checks++;
    if (b_resp !== 2'b11) begin errors++; $display("FAIL decerr_b got %0h want 3", b_resp); end
    rd(32'h1000, 0, 2'b01, 4'h0);
    checks++;
    if (rrbuf[0] !== 2'b11 || rbuf[0] !== 32'h0) begin
      errors++; $display("FAIL decerr_r got resp %0h data %0h want 3 0", rrbuf[0], rbuf[0]);
    end
    for (int i = 0; i < 4; i++) wbuf[i] = 32'h77;
    send_aw(32'h80, 3, 2'b01, 3'd2, 4'h0);
    send_w(3, 1);
    recv_b();
    checks++;
    if (b_resp !== 2'b10) begin errors++; $display("FAIL early_wlast got %0h want 2", b_resp); end
    send_ar(32'h10, 0, 2'b01, 3'd1, 4'h0);
    recv_r(0, -1);
    checks++;
    if (rrbuf[0] !== 2'b10 || rbuf[0] !== 32'h0) begin
      errors++; $display("FAIL bad_size got resp %0h data %0h want 2 0", rrbuf[0], rbuf[0]);
    end
    wbuf[0] = 32'hE1; wbuf[1] = 32'hE2;
    wr(32'hFF8, 1, 2'b01, 4'h0);
    rd(32'hFF8, 3, 2'b01, 4'h0);
    checks++;
    if (rbuf[0] !== 32'hE1 || rbuf[1] !== 32'hE2 || rbuf[2] !== 0 || rbuf[3] !== 0 ||
        {rrbuf[0], rrbuf[1], rrbuf[2], rrbuf[3]} !== 8'b00001111) begin
      errors++; $display("FAIL incr_end got %0h %0h %0h %0h resp %0h%0h%0h%0h want e1 e2 0 0 0033",
        rbuf[0], rbuf[1], rbuf[2], rbuf[3], rrbuf[0], rrbuf[1], rrbuf[2], rrbuf[3]);
    end
    wr(32'hFFC, 1, 2'b01, 4'h0);
    checks++;
    if (b_resp !== 2'b11) begin errors++; $display("FAIL incr_end_b got %0h want 3", b_resp); end
  endtask

  task automatic test_max_len();
    int bad, lasts;
    for (int i = 0; i < 256; i++) wbuf[i] = 32'hC000_0000 + 32'(i);
    wr(32'h190, 255, 2'b01, 4'h7);
    checks++;
    if (b_resp !== 2'b00 || b_id !== 4'h7) begin
      errors++; $display("FAIL maxlen_b got resp %0h id %0h want 0 7", b_resp, b_id);
    end
    rd(32'h190, 255, 2'b01, 4'h0);
    bad = 0; lasts = 0;
    for (int i = 0; i < 256; i++) begin
      if (rbuf[i] !== 32'hC000_0000 + 32'(i)) bad++;
      if (rlbuf[i] === 1'b1) lasts++;
    end
    checks++;
    if (bad !== 0 || lasts !== 1 || rlbuf[255] !== 1'b1 || gaps !== 0) begin
      errors++; $display("FAIL maxlen_r got bad %0d lasts %0d gaps %0d want 0 1 0", bad, lasts, gaps);
    end
  endtask

  task automatic test_back_to_back();
    wbuf[0] = 32'h1111_1111;
    wr(32'hC8, 0, 2'b01, 4'h0);
    bus.awaddr = 32'hC8; bus.awlen = 8'd0; bus.awburst = 2'b01; bus.awsize = 3'd2; bus.awid = 4'h0;
    bus.araddr = 32'hC8; bus.arlen = 8'd0; bus.arburst = 2'b01; bus.arsize = 3'd2; bus.arid = 4'h0;
    bus.awvalid = 1'b1; bus.arvalid = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.arready !== 1'b1 || bus.awready !== 1'b0) begin
      errors++; $display("FAIL arb_read_first got ar %b aw %b want 1 0", bus.arready, bus.awready);
    end
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    recv_r(0, -1);
    checks++;
    if (rbuf[0] !== 32'h1111_1111) begin errors++; $display("FAIL arb_old_data got %h want 11111111", rbuf[0]); end
    wbuf[0] = 32'h2222_2222;
    send_aw(32'hC8, 0, 2'b01, 3'd2, 4'h0);
    send_w(0, -1);
    recv_b();
    rd(32'hCC, 0, 2'b01, 4'h0);
    bus.awaddr = 32'hD0; bus.awvalid = 1'b1;
    bus.araddr = 32'hC8; bus.arvalid = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.awready !== 1'b1 || bus.arready !== 1'b0) begin
      errors++; $display("FAIL arb_alternate got aw %b ar %b want 1 0", bus.awready, bus.arready);
    end
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    wbuf[0] = 32'h3333_3333;
    send_w(0, -1);
    recv_b();
    send_ar(32'hC8, 0, 2'b01, 3'd2, 4'h0);
    recv_r(0, -1);
    checks++;
    if (rbuf[0] !== 32'h2222_2222) begin errors++; $display("FAIL arb_new_data got %h want 22222222", rbuf[0]); end
  endtask

  task automatic test_reset_mid();
    send_ar(32'h190, 7, 2'b01, 3'd2, 4'h0);
    bus.rready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.rready = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.rvalid !== 1'b0 || bus.rdata !== 32'h0) begin
      errors++; $display("FAIL reset_mid got rvalid %b rdata %h want 0 0", bus.rvalid, bus.rdata);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd(32'h190, 1, 2'b01, 4'h9);
    checks++;
    if (rbuf[0] !== 32'hC000_0000 || rbuf[1] !== 32'hC000_0001 || rrbuf[1] !== 2'b00 ||
        rlbuf[1] !== 1'b1 || ridbuf[0] !== 4'h9) begin
      errors++; $display("FAIL reset_recover got %h %h resp %0h last %b id %0h want c0000000 c0000001 0 1 9",
        rbuf[0], rbuf[1], rrbuf[1], rlbuf[1], ridbuf[0]);
    end
  endtask

  initial begin
    bus.awvalid = 0; bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
    bus.wvalid = 0; bus.wid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.bready = 0;
    bus.arvalid = 0; bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
    bus.rready = 0;
    for (int i = 0; i < 256; i++) sbuf[i] = 4'hF;
    test_reset();
    test_single();
    test_incr_read();
    test_wrap();
    test_strobe();
    test_fixed();
    test_errors();
    test_max_len();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
